booth_mul4: RTL and testbench

- Sequential signed 4x4 -> 8-bit multiplier using radix-2 Booth recoding. One partial-product step per clock.
- Drives the existing 4-bit `adder` add/subtract stage and consumes its F, of outputs.
- First iterative datapath block built on the adder. Precursor to the lab ALU's MUL instruction.

---
 rtl/mul_pkg.sv | 9 +
 rtl/adder.sv | 16 +
 rtl/booth_mul4.sv | 82 ++++++++
 tb/tb_booth_mul4.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and Booth pair codes for the multiplier
package mul_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;
  typedef enum logic [1:0] {IDLE = S_IDLE, CALC = S_CALC, DONE = S_DONE} state_t;
endpackage

// File: rtl/adder.sv
// adder: 4-bit combinational add/subtract stage with carry, zero and signed overflow flags
module adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       addsub,
  output logic [3:0] F,
  output logic       cf,
  output logic       zero,
  output logic       of
);
  logic [3:0] bx;
  assign bx = B ^ {4{addsub}};
  assign {cf, F} = {1'b0, A} + {1'b0, bx} + {4'b0, addsub};
  assign zero = F == 4'd0;
  assign of = (A[3] == bx[3]) && (F[3] != A[3]);
endmodule

// File: rtl/booth_mul4.sv
// booth_mul4: sequential signed 4x4 radix-2 Booth multiplier, one step per clock on the shared adder
module booth_mul4
  import mul_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product,
  output logic           zero
);
  state_t state_q;
  logic [N-1:0] acc_q, q_q, m_q, acc_d, q_d, f;
  logic [CW-1:0] count_q;
  logic [2*N-1:0] product_q;
  logic q1_q, busy_q, done_q, zero_q, of, s;
  logic cf_unused, zero_unused;
  logic [1:0] pair;
  assign pair = {q_q[0], q1_q};
  adder u_adder (
    .A(acc_q),
    .B((pair == BOOTH_ADD || pair == BOOTH_SUB) ? m_q : '0),
    .addsub(pair == BOOTH_SUB),
    .F(f),
    .cf(cf_unused),
    .zero(zero_unused),
    .of(of)
  );
  // F[3] alone is the wrong sign when ACC-M overflows (M=-8); use the 5-bit result sign
  assign s = f[N-1] ^ of;
  assign acc_d = {s, f[N-1:1]};
  assign q_d = {f[0], q_q[N-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q <= '0;
      q_q <= '0;
      q1_q <= 1'b0;
      m_q <= '0;
      count_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      product_q <= '0;
      zero_q <= 1'b0;
    end else if (state_q == CALC) begin
      acc_q <= acc_d;
      q_q <= q_d;
      q1_q <= q_q[0];
      count_q <= count_q + CW'(1);
      if (count_q == CW'(N - 1)) begin
        product_q <= {acc_d, q_d};
        zero_q <= {acc_d, q_d} == '0;
        busy_q <= 1'b0;
        done_q <= 1'b1;
        state_q <= DONE;
      end
    end else begin
      done_q <= 1'b0;
      if (start) begin
        m_q <= a;
        q_q <= b;
        acc_q <= '0;
        q1_q <= 1'b0;
        count_q <= '0;
        busy_q <= 1'b1;
        state_q <= CALC;
      end else begin
        state_q <= IDLE;
      end
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign product = product_q;
  assign zero = zero_q;
endmodule

// File: tb/tb_booth_mul4.sv
// tb_booth_mul4: directed and exhaustive checks of booth_mul4 against a cycle-timeline product model
module tb_booth_mul4;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [3:0] a = '0, b = '0;
  logic busy, done, zero;
  logic [7:0] product;
  int n_chk = 0, n_fail = 0;
  booth_mul4 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product), .zero(zero)
  );
  always #5 clk = ~clk;
  // model: an accepted start at edge k gives busy after edges k..k+3, done after k+4
  int cyc = 0, k = 0, p;
  bit act = 1'b0;
  logic [7:0] pend = '0, exp_p = '0;
  logic exp_z = 1'b0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act = 1'b0;
      exp_p = '0;
      exp_z = 1'b0;
    end else begin
      cyc++;
      if (act && cyc - k == 4) begin
        exp_p = pend;
        exp_z = pend == 8'h00;
      end
      if (start && (!act || cyc - k >= 5)) begin
        act = 1'b1;
        k = cyc;
        p = $signed(a) * $signed(b);
        pend = p[7:0];
      end
    end
  end
  task automatic chk(input string nm, input logic [7:0] act_v, input logic [7:0] exp_v);
    n_chk++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act_v, exp_v, $time);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_busy", busy, act && (cyc - k) <= 3);
      chk("model_done", done, act && (cyc - k) == 4);
      chk("model_product", product, exp_p);
      chk("model_zero", zero, exp_z);
    end
  end
  task automatic wait_done(input string nm);
    int t = 0;
    while (!done && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got done=0 expected done=1", nm);
    end
  endtask
  task automatic run(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e, input string nm);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(nm);
    chk(nm, product, e);
    chk({nm, "_zero"}, zero, e == 8'h00);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nd, pr;
    logic [7:0] e;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 8'h00);
    chk("rst_zero", zero, 0);
    #20;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    a = 4'd3;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    repeat (3) begin
      nd += int'(busy);
      @(negedge clk);
    end
    nd += int'(busy);
    chk("busy_4_cycles", 8'(nd), 8'd4);
    wait_done("m3x2");
    chk("m3x2", product, 8'h06);
    chk("m3x2_zero", zero, 0);
    run(4'h8, 4'h8, 8'h40, "m_8x_8");
    run(4'h8, 4'h7, 8'hC8, "m_8x7");
    run(4'h7, 4'h7, 8'h31, "m7x7");
    run(4'hF, 4'hF, 8'h01, "m_1x_1");
    run(4'h0, 4'hB, 8'h00, "m0x_5");
    run(4'h5, 4'h0, 8'h00, "m5x0");
    @(negedge clk);
    a = 4'd3;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 4'd1;
    b = 4'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignore");
    chk("ignore", product, 8'h09);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      nd += int'(done);
    end
    chk("ignore_single_done", 8'(nd), 8'd0);
    @(negedge clk);
    a = 4'd2;
    b = 4'd3;
    start = 1'b1;
    @(negedge clk);
    a = 4'hD;
    b = 4'd5;
    wait_done("b2b_first");
    chk("b2b_first", product, 8'h06);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", busy, 1);
    wait_done("b2b_second");
    chk("b2b_second", product, 8'hF1);
    @(negedge clk);
    a = 4'd3;
    b = 4'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    chk("async_product", product, 8'h00);
    chk("async_zero", zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(4'hD, 4'h6, 8'hEE, "after_reset");
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        pr = $signed(4'(i)) * $signed(4'(j));
        e = pr[7:0];
        run(4'(i), 4'(j), e, "sweep");
      end
    end
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
